// File: rtl/recv_queue.sv
// Receive FIFO: single-clock queue with sticky overflow and a saturating drop counter.
// Status outputs come only from registered state; out_data is a combinational read at tail.
module recv_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     new_in,
    input  logic [WIDTH-1:0]         newdata,
    input  logic                     out_ready,
    input  logic                     clear_ovf,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     qfull,
    output logic                     qempty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             push;
    logic             pop;
    logic             drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign qempty    = (count == '0);
    assign qfull     = (count == FULL_CNT);
    assign out_valid = ~qempty;
    assign out_data  = mem[tail];

    // A full queue still accepts a word when the oldest one leaves in the same cycle.
    assign pop  = out_ready & out_valid;
    assign push = new_in & (~qfull | pop);
    assign drop = new_in & qfull & ~pop;

    // Storage is data only and is never reset; a stale entry is unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[head] <= newdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                head <= head + PTR_ONE;
            end
            if (pop) begin
                tail <= tail + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // A drop in the same cycle as clear_ovf wins, leaving a fresh count of one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clear_ovf ? 8'd1 : sat_inc(drop_cnt);
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_recv_queue.sv
// Directed bench for recv_queue (WIDTH=8, DEPTH=8) with immediate-assertion checks.
module tb_recv_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_in;
    logic [7:0] newdata;
    logic       out_ready;
    logic       clear_ovf;
    logic       out_valid;
    logic [7:0] out_data;
    logic       qfull;
    logic       qempty;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] mq[$];

    recv_queue #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .new_in(new_in), .newdata(newdata),
        .out_ready(out_ready), .clear_ovf(clear_ovf), .out_valid(out_valid),
        .out_data(out_data), .qfull(qfull), .qempty(qempty), .count(count),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; new_in = 1'b0; newdata = 8'h00; out_ready = 1'b0; clear_ovf = 1'b0;
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_qempty", 32'(qempty), 1);
        chk("rst_qfull", 32'(qfull), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // Three pushes, first one in the first cycle out of reset
        rst = 1'b1; new_in = 1'b1; newdata = 8'h11;
        step();
        chk("first_push_count", 32'(count), 1);
        chk("first_push_data", 32'(out_data), 32'h11);
        newdata = 8'h22; step();
        newdata = 8'h33; step();
        new_in = 1'b0;
        chk("s1_count", 32'(count), 3);
        chk("s1_head_data", 32'(out_data), 32'h11);
        chk("s1_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step(); chk("s1_pop1", 32'(out_data), 32'h22);
        step(); chk("s1_pop2", 32'(out_data), 32'h33);
        step(); chk("s1_empty", 32'(qempty), 1);
        out_ready = 1'b0;

        // Fill, overflow, drain
        new_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            newdata = 8'(8'hA0 + i);
            step();
        end
        chk("s2_qfull", 32'(qfull), 1);
        chk("s2_count", 32'(count), 8);
        newdata = 8'hFF; step();
        new_in = 1'b0;
        chk("s2_ovf", 32'(overflow), 1);
        chk("s2_drop", 32'(drop_cnt), 1);
        chk("s2_count_after_drop", 32'(count), 8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s2_pop%0d", i), 32'(out_data), 32'(8'hA0 + i));
            step();
        end
        out_ready = 1'b0;
        chk("s2_empty", 32'(qempty), 1);
        chk("s2_ovf_sticky", 32'(overflow), 1);
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk("s2_clear_ovf", 32'(overflow), 0);
        chk("s2_clear_drop", 32'(drop_cnt), 0);

        // Full queue, push and pop together
        new_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            newdata = 8'(8'hB0 + i);
            step();
        end
        newdata = 8'h55; out_ready = 1'b1;
        step();
        new_in = 1'b0;
        chk("s3_count", 32'(count), 8);
        chk("s3_qfull", 32'(qfull), 1);
        chk("s3_ovf", 32'(overflow), 0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("s3_pop%0d", i), 32'(out_data), 32'(8'hB0 + i));
            step();
        end
        chk("s3_last", 32'(out_data), 32'h55);
        step();
        out_ready = 1'b0;
        chk("s3_empty", 32'(qempty), 1);

        // Empty queue, push and ready together
        new_in = 1'b1; newdata = 8'h3C; out_ready = 1'b1;
        step();
        new_in = 1'b0;
        chk("s4_count", 32'(count), 1);
        chk("s4_valid", 32'(out_valid), 1);
        chk("s4_data", 32'(out_data), 32'h3C);
        step();
        out_ready = 1'b0;
        chk("s4_empty", 32'(qempty), 1);

        // Drop counter saturation and clear/drop interaction
        new_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            newdata = 8'(8'hC0 + i);
            step();
        end
        newdata = 8'hEE;
        for (int i = 0; i < 255; i++) step();
        chk("s5_drop_255", 32'(drop_cnt), 255);
        for (int i = 0; i < 45; i++) step();
        new_in = 1'b0;
        chk("s5_drop_sat", 32'(drop_cnt), 255);
        chk("s5_ovf", 32'(overflow), 1);
        chk("s5_count", 32'(count), 8);
        chk("s5_unchanged", 32'(out_data), 32'hC0);
        clear_ovf = 1'b1; step();
        chk("s5_clr_ovf", 32'(overflow), 0);
        chk("s5_clr_drop", 32'(drop_cnt), 0);
        new_in = 1'b1; step();
        new_in = 1'b0; clear_ovf = 1'b0;
        chk("s5_setwins_ovf", 32'(overflow), 1);
        chk("s5_setwins_drop", 32'(drop_cnt), 1);

        // Mid-operation reset with five words queued
        rst = 1'b0; step(); rst = 1'b1;
        new_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            newdata = 8'(8'hD0 + i);
            step();
        end
        chk("s6_pre_count", 32'(count), 5);
        rst = 1'b0; out_ready = 1'b1; clear_ovf = 1'b1; newdata = 8'h99;
        step();
        rst = 1'b1; new_in = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        chk("s6_count", 32'(count), 0);
        chk("s6_qempty", 32'(qempty), 1);
        chk("s6_valid", 32'(out_valid), 0);

        // Interleaved traffic against a queue model, wrapping the pointers
        mq.delete();
        for (int i = 0; i < 20; i++) begin
            logic do_pop;
            logic do_push;
            new_in = (i % 3) != 2;
            out_ready = (i % 2) == 1;
            newdata = 8'(8'h60 + i);
            chk($sformatf("s7_valid%0d", i), 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk($sformatf("s7_data%0d", i), 32'(out_data), 32'(mq[0]));
            do_pop = out_ready && (mq.size() > 0);
            do_push = new_in && ((mq.size() < 8) || do_pop);
            step();
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(newdata);
            chk($sformatf("s7_count%0d", i), 32'(count), 32'(mq.size()));
        end
        new_in = 1'b0; out_ready = 1'b1;
        while (mq.size() > 0) begin
            chk("s7_drain", 32'(out_data), 32'(mq[0]));
            void'(mq.pop_front());
            step();
        end
        out_ready = 1'b0;
        chk("s7_empty", 32'(qempty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
